// File: rtl/vga_timing_driver_if.sv
// Pixel-source side of the VGA driver: coordinates out, RGB888 back.
// The master drives coordinates and the slave returns pixel_data.
interface vga_timing_driver_if #(
  parameter int COOR_WIDTH = 12
);
  logic [COOR_WIDTH-1:0] x_pixel;
  logic [COOR_WIDTH-1:0] y_pixel;
  logic                  ena;
  logic                  frame_start;
  logic [23:0]           pixel_data;

  modport master (output x_pixel, y_pixel, ena, frame_start, input pixel_data);
  modport slave  (input x_pixel, y_pixel, ena, frame_start, output pixel_data);
endinterface

// File: rtl/vga_timing_driver.sv
// VGA raster timing generator: drives coordinates to a fixed-latency pixel source
// and emits hsync/vsync/de/rgb aligned to that source's returned data.
module vga_timing_driver #(
  parameter int COOR_WIDTH  = 12,
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter bit HS_POL      = 1'b0,
  parameter bit VS_POL      = 1'b0,
  parameter int PIX_LATENCY = 1
) (
  input  logic                vga_clk,
  input  logic                rst_n,
  vga_timing_driver_if.master pix,
  output logic                hsync,
  output logic                vsync,
  output logic                de,
  output logic [23:0]         rgb
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int STAGES  = PIX_LATENCY + 1;

  typedef logic [COOR_WIDTH-1:0] coor_t;

  localparam coor_t H_ACT_C = coor_t'(H_ACTIVE);
  localparam coor_t HS_BEG  = coor_t'(H_ACTIVE + H_FP);
  localparam coor_t HS_END  = coor_t'(H_ACTIVE + H_FP + H_SYNC);
  localparam coor_t H_LAST  = coor_t'(H_TOTAL - 1);
  localparam coor_t V_ACT_C = coor_t'(V_ACTIVE);
  localparam coor_t VS_BEG  = coor_t'(V_ACTIVE + V_FP);
  localparam coor_t VS_END  = coor_t'(V_ACTIVE + V_FP + V_SYNC);
  localparam coor_t V_LAST  = coor_t'(V_TOTAL - 1);

  generate
    if (H_TOTAL >= 2**COOR_WIDTH || V_TOTAL >= 2**COOR_WIDTH) begin : g_bad_width
      $error("vga_timing_driver: H_TOTAL/V_TOTAL do not fit in COOR_WIDTH");
    end
    if (PIX_LATENCY < 0 || PIX_LATENCY > 4) begin : g_bad_lat
      $error("vga_timing_driver: PIX_LATENCY out of range 0..4");
    end
  endgenerate

  coor_t h_cnt, v_cnt;
  logic  active, hs_raw, vs_raw;

  // Bit 0 is the coordinate stage; bit STAGES lines up with rgb.
  logic [STAGES:0] vld_pipe, hs_pipe, vs_pipe;

  always_ff @(posedge vga_clk) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + coor_t'(1);
    end else begin
      h_cnt <= h_cnt + coor_t'(1);
    end
  end

  always_comb begin
    active = (h_cnt < H_ACT_C) && (v_cnt < V_ACT_C);
    hs_raw = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
    vs_raw = (v_cnt >= VS_BEG) && (v_cnt < VS_END);
  end

  always_ff @(posedge vga_clk) begin
    if (!rst_n) begin
      pix.x_pixel     <= '0;
      pix.y_pixel     <= '0;
      pix.frame_start <= 1'b0;
      pix.ena         <= 1'b0;
      vld_pipe        <= '0;
      hs_pipe         <= '0;
      vs_pipe         <= '0;
      rgb             <= '0;
    end else begin
      pix.x_pixel     <= active ? h_cnt + coor_t'(1) : '0;
      pix.y_pixel     <= active ? v_cnt + coor_t'(1) : '0;
      pix.frame_start <= (h_cnt == '0) && (v_cnt == '0);
      pix.ena         <= 1'b1;
      vld_pipe        <= {vld_pipe[STAGES-1:0], active};
      hs_pipe         <= {hs_pipe[STAGES-1:0], hs_raw};
      vs_pipe         <= {vs_pipe[STAGES-1:0], vs_raw};
      // Source data for a coordinate is valid while its bit sits one stage before de.
      rgb             <= vld_pipe[STAGES-1] ? pix.pixel_data : 24'h0;
    end
  end

  assign de    = vld_pipe[STAGES];
  assign hsync = hs_pipe[STAGES] ? HS_POL : ~HS_POL;
  assign vsync = vs_pipe[STAGES] ? VS_POL : ~VS_POL;

endmodule

// File: tb/tb_vga_timing_driver.sv
// Directed bench: default 640x480 timing plus two tiny rasters (latency 2 / latency 0,
// both sync polarities) checked cycle by cycle against a closed-form raster model.
module tb_vga_timing_driver;
  logic vga_clk = 1'b0;
  logic rst_n   = 1'b0;
  always #5 vga_clk = ~vga_clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h @%0t", tag, obs, exp, $time);
    end
  endtask

  // Default 640x480, PIX_LATENCY=1
  vga_timing_driver_if #(.COOR_WIDTH(12)) pd();
  logic d_hs, d_vs, d_de;
  logic [23:0] d_rgb;
  vga_timing_driver u_d (
    .vga_clk(vga_clk), .rst_n(rst_n), .pix(pd),
    .hsync(d_hs), .vsync(d_vs), .de(d_de), .rgb(d_rgb)
  );
  always_ff @(posedge vga_clk) pd.pixel_data <= {pd.x_pixel[7:0], pd.y_pixel[7:0], 8'hA5};

  // Tiny raster, PIX_LATENCY=2, active-low syncs
  vga_timing_driver_if #(.COOR_WIDTH(8)) ps();
  logic s_hs, s_vs, s_de;
  logic [23:0] s_rgb, s_src1;
  vga_timing_driver #(
    .COOR_WIDTH(8), .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .PIX_LATENCY(2)
  ) u_s (
    .vga_clk(vga_clk), .rst_n(rst_n), .pix(ps),
    .hsync(s_hs), .vsync(s_vs), .de(s_de), .rgb(s_rgb)
  );
  always_ff @(posedge vga_clk) begin
    s_src1        <= {ps.x_pixel[7:0], ps.y_pixel[7:0], 8'hA5};
    ps.pixel_data <= s_src1;
  end

  // Tiny raster, PIX_LATENCY=0 (combinational source), active-high syncs
  vga_timing_driver_if #(.COOR_WIDTH(8)) pp();
  logic p_hs, p_vs, p_de;
  logic [23:0] p_rgb;
  vga_timing_driver #(
    .COOR_WIDTH(8), .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .PIX_LATENCY(0)
  ) u_p (
    .vga_clk(vga_clk), .rst_n(rst_n), .pix(pp),
    .hsync(p_hs), .vsync(p_vs), .de(p_de), .rgb(p_rgb)
  );
  assign pp.pixel_data = {pp.x_pixel[7:0], pp.y_pixel[7:0], 8'hA5};

  task automatic rst_chk(input string t, input logic [11:0] x, y, input logic fs, hsy, vsy, dee, ena,
                         input logic [23:0] rgbv, input bit hp, vp);
    chk({t, ".x"},     32'(x),    32'd0);
    chk({t, ".y"},     32'(y),    32'd0);
    chk({t, ".fs"},    32'(fs),   32'd0);
    chk({t, ".hsync"}, 32'(hsy),  32'(!hp));
    chk({t, ".vsync"}, 32'(vsy),  32'(!vp));
    chk({t, ".de"},    32'(dee),  32'd0);
    chk({t, ".ena"},   32'(ena),  32'd0);
    chk({t, ".rgb"},   32'(rgbv), 32'd0);
  endtask

  // k = number of clock edges since reset release; coordinates reflect counter
  // position k-1, sync/de/rgb reflect position k-l-2.
  task automatic model_chk(input string t, input int k, input int ha, hf, hs, hb, va, vf, vs, vb, l,
                           input bit hp, vp, input logic [11:0] x, y,
                           input logic fs, hsy, vsy, dee, ena, input logic [23:0] rgbv);
    int ht, vt, p, h, v;
    bit act, hsr, vsr;
    ht = ha + hf + hs + hb;
    vt = va + vf + vs + vb;
    p = k - 1;
    h = p % ht;
    v = (p / ht) % vt;
    act = (h < ha) && (v < va);
    chk({t, ".x"},   32'(x),   act ? h + 1 : 0);
    chk({t, ".y"},   32'(y),   act ? v + 1 : 0);
    chk({t, ".fs"},  32'(fs),  32'(h == 0 && v == 0));
    chk({t, ".ena"}, 32'(ena), 32'd1);
    p = k - l - 2;
    act = 1'b0; hsr = 1'b0; vsr = 1'b0; h = 0; v = 0;
    if (p >= 0) begin
      h   = p % ht;
      v   = (p / ht) % vt;
      act = (h < ha) && (v < va);
      hsr = (h >= ha + hf) && (h < ha + hf + hs);
      vsr = (v >= va + vf) && (v < va + vf + vs);
    end
    chk({t, ".de"},    32'(dee),  32'(act));
    chk({t, ".hsync"}, 32'(hsy),  32'(hsr ? hp : !hp));
    chk({t, ".vsync"}, 32'(vsy),  32'(vsr ? vp : !vp));
    chk({t, ".rgb"},   32'(rgbv), act ? 32'({8'(h + 1), 8'(v + 1), 8'hA5}) : 32'd0);
  endtask

  task automatic all_model(input int k);
    model_chk("d", k, 640, 16, 96, 48, 480, 10, 2, 33, 1, 1'b0, 1'b0, pd.x_pixel, pd.y_pixel,
              pd.frame_start, d_hs, d_vs, d_de, pd.ena, d_rgb);
    model_chk("s", k, 4, 1, 2, 1, 3, 1, 1, 1, 2, 1'b0, 1'b0, 12'(ps.x_pixel), 12'(ps.y_pixel),
              ps.frame_start, s_hs, s_vs, s_de, ps.ena, s_rgb);
    model_chk("p", k, 4, 1, 2, 1, 3, 1, 1, 1, 0, 1'b1, 1'b1, 12'(pp.x_pixel), 12'(pp.y_pixel),
              pp.frame_start, p_hs, p_vs, p_de, pp.ena, p_rgb);
  endtask

  task automatic all_rst(input string t);
    rst_chk({t, ".d"}, pd.x_pixel, pd.y_pixel, pd.frame_start, d_hs, d_vs, d_de, pd.ena, d_rgb, 1'b0, 1'b0);
    rst_chk({t, ".s"}, 12'(ps.x_pixel), 12'(ps.y_pixel), ps.frame_start, s_hs, s_vs, s_de, ps.ena, s_rgb,
            1'b0, 1'b0);
    rst_chk({t, ".p"}, 12'(pp.x_pixel), 12'(pp.y_pixel), pp.frame_start, p_hs, p_vs, p_de, pp.ena, p_rgb,
            1'b1, 1'b1);
  endtask

  initial begin
    int d_de_cnt, d_hs_low, d_fall1, d_fall2, d_run;
    int s_fs_cnt, s_fs_last, s_gap, s_vs_low, s_de_cnt;
    logic d_hs_prev;
    d_de_cnt = 0; d_hs_low = 0; d_fall1 = -1; d_fall2 = -1; d_run = -1;
    s_fs_cnt = 0; s_fs_last = -1; s_gap = -1; s_vs_low = 0; s_de_cnt = 0;
    d_hs_prev = 1'b1;

    // Sustained reset: outputs hold reset values every clock
    rst_n = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge vga_clk);
      all_rst("rst_hold");
    end
    rst_n = 1'b1;

    for (int k = 1; k <= 2420; k++) begin
      @(negedge vga_clk);
      if (k == 1) begin
        chk("first_x", 32'(pd.x_pixel), 32'd1);
        chk("first_y", 32'(pd.y_pixel), 32'd1);
      end
      all_model(k);
      d_de_cnt += int'(d_de);
      d_hs_low += int'(!d_hs);
      if (d_hs_prev && !d_hs) begin
        if (d_fall1 < 0) d_fall1 = k;
        else if (d_fall2 < 0) d_fall2 = k;
      end
      if (!d_hs_prev && d_hs && d_fall1 >= 0 && d_run < 0) d_run = k - d_fall1;
      d_hs_prev = d_hs;
      if (ps.frame_start) begin
        s_fs_cnt++;
        if (s_fs_last >= 0) s_gap = k - s_fs_last;
        s_fs_last = k;
      end
      s_vs_low += int'(!s_vs);
      s_de_cnt += int'(s_de);
    end

    chk("d.hs_width",    32'(d_run),           32'd96);
    chk("d.hs_period",   32'(d_fall2 - d_fall1), 32'd800);
    chk("d.hs_low_cnt",  32'(d_hs_low),        32'd288);
    chk("d.de_cnt",      32'(d_de_cnt),        32'd1938);
    chk("s.fs_cnt",      32'(s_fs_cnt),        32'd51);
    chk("s.fs_period",   32'(s_gap),           32'd48);
    chk("s.vs_low_cnt",  32'(s_vs_low),        32'd400);
    chk("s.de_cnt",      32'(s_de_cnt),        32'd609);

    // Mid-frame reset (tiny rasters sit at line 2, column 3)
    rst_n = 1'b0;
    @(negedge vga_clk);
    all_rst("rst_mid");
    rst_n = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      @(negedge vga_clk);
      all_model(k);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/vga_timing_driver.md
Name: vga_timing_driver

Overview:
- Generates VGA raster timing and drives the display side of the pixel interface: issues x_pixel/y_pixel coordinates to the pixel source and collects the 24-bit pixel_data returned.
- Produces hsync, vsync, de and registered rgb, with every output aligned to the pixel source's fixed latency.
- Sits between the painter-style pixel generators and the VGA output pins. Defaults are 640x480@60 with a 25 MHz vga_clk.

Parameters:
- COOR_WIDTH, 12, width of the coordinate outputs and internal counters
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, hsync pulse width (clocks)
- H_BP, 48, horizontal back porch (clocks)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- HS_POL, 0, hsync asserted level (0 = active-low)
- VS_POL, 0, vsync asserted level (0 = active-low)
- PIX_LATENCY, 1, clocks from a coordinate change to valid pixel_data (range 0..4)

Ports:
- vga_clk, input, 1, pixel clock
- rst_n, input, 1, reset; synchronous, active-low; clock vga_clk
- pixel_data, input, 24, RGB888 from the pixel source for the coordinate issued PIX_LATENCY clocks earlier
- x_pixel, output, COOR_WIDTH, active column, 1-based (1..H_ACTIVE); 0 in blanking
- y_pixel, output, COOR_WIDTH, active line, 1-based (1..V_ACTIVE); 0 in blanking
- ena, output, 1, pixel-source/ROM enable
- frame_start, output, 1, one-clock pulse at the first active coordinate of each frame
- hsync, output, 1, horizontal sync
- vsync, output, 1, vertical sync
- de, output, 1, display enable, aligned with rgb
- rgb, output, 24, pixel to the DAC/pins

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
- Counters:
  - h_cnt counts 0..H_TOTAL-1 and wraps to 0.
  - v_cnt increments on each h_cnt wrap and wraps 0..V_TOTAL-1.
  - Region order per axis: active, front porch, sync, back porch.
- Active condition: active = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
- Hsync condition: hs_raw asserted for H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC.
- Vsync condition: vs_raw asserted for V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC. The vsync window covers whole lines, including the blanking part of each line.
- Coordinate stage (latency 1 from the counters):
  - When active, register x_pixel = h_cnt+1 and y_pixel = v_cnt+1. Otherwise register 0 on both.
  - frame_start registers (h_cnt==0 && v_cnt==0).
- Delay stage:
  - active, hs_raw and vs_raw each pass through a shift register of PIX_LATENCY+1 stages after the coordinate stage.
  - hsync, vsync and de are taken from the last stage, so their total latency from the counters is PIX_LATENCY+2.
  - hsync = HS_POL when its delayed raw bit is 1, else ~HS_POL. vsync uses VS_POL in the same way.
- rgb: registered. rgb <= pixel_data when the delayed active bit (one stage before de) is 1, else 24'h0. rgb therefore changes on the same edge as de, and blanking always drives black.
- ena: registered 1 on every clock while rst_n is high. It drops to 0 only during reset.
- Reset (rst_n==0 sampled on a vga_clk edge), applies also mid-frame:
  - h_cnt and v_cnt clear to 0.
  - x_pixel, y_pixel and frame_start clear to 0.
  - All delay stages clear to inactive.
  - hsync = ~HS_POL, vsync = ~VS_POL, de = 0, rgb = 0, ena = 0.
- First clock after reset release: counters start at 0, so the first frame is complete. frame_start pulses one clock after release.
- Width rule: compute all compares at COOR_WIDTH bits. Implementation asserts (elaboration check) H_TOTAL < 2**COOR_WIDTH and V_TOTAL < 2**COOR_WIDTH.
- Line wrap: x_pixel goes H_ACTIVE then 0 (front porch) with no intermediate value.
- Frame wrap: line V_ACTIVE ends, then y_pixel is held 0 for all V_FP+V_SYNC+V_BP lines.
- PIX_LATENCY = 0: pixel_data is combinational from x/y; the delay is 1 stage.

Test Plan:
- Defaults, release reset and run 2 frames:
  - hsync low for exactly 96 clocks, period 800.
  - vsync low for 1600 clocks (2 lines), period 420000.
  - de high 640 clocks per line on 480 lines (307200 per frame).
  - frame_start pulses every 420000 clocks.
- Coordinate check, defaults:
  - First active clock after release: x_pixel=1, y_pixel=1.
  - 639 clocks later: x_pixel=640, then 0 for 160 clocks.
  - Last active coordinate per frame is (640,480).
- Latency, PIX_LATENCY=1, model source returning pixel_data={x[7:0],y[7:0],8'hA5} one clock after the coordinate: every rgb sample with de=1 matches its coordinate, rgb=0 whenever de=0, and hsync/vsync edges stay consistent relative to de.
- Small-parameter config (H_ACTIVE=4, H_FP=1, H_SYNC=2, H_BP=1, V_ACTIVE=3, V_FP=1, V_SYNC=1, V_BP=1, PIX_LATENCY=2):
  - Line period 8, frame period 48.
  - hsync low at h_cnt 5..6 (delayed by 4).
  - Positive polarity (HS_POL=VS_POL=1) inverts the sync levels only.
- Reset mid-frame at v_cnt=200, h_cnt=300:
  - Next clock: hsync=vsync=1, de=0, rgb=0, ena=0, x/y=0.
  - After release, timing restarts from (0,0) and frame_start pulses.
- Sustained reset for 10 clocks:
  - All outputs hold their reset values throughout.
  - ena returns to 1 on the first clock after release.
